// File: rtl/mm_pkg.sv
// Shared constants, sequencer state type and {row,col} element packing for the 4x4 matmul.
package mm_pkg;
   localparam int DIM   = 4;
   localparam int IDX_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_MAC,
      S_WB,
      S_DONE
   } mm_seq_state_t;

   // Row-major flattening, used identically by the operand muxes and the C register file.
   function automatic logic [2*IDX_W-1:0] elem_idx(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
      return {row, col};
   endfunction
endpackage

// File: rtl/mm_mac_sequencer_if.sv
// Control bundle between the matmul sequencer (master) and the start/done host plus datapath (slave).
interface mm_mac_sequencer_if;
   import mm_pkg::*;

   logic                 start;
   logic                 stall;
   logic                 busy;
   logic                 done;
   logic [2*IDX_W-1:0]   sel_a;
   logic [2*IDX_W-1:0]   sel_b;
   logic                 mac_clr;
   logic                 mac_en;
   logic                 wr_en;
   logic [2*IDX_W-1:0]   wr_addr;

   modport master (
      input  start, stall,
      output busy, done, sel_a, sel_b, mac_clr, mac_en, wr_en, wr_addr
   );

   modport slave (
      output start, stall,
      input  busy, done, sel_a, sel_b, mac_clr, mac_en, wr_en, wr_addr
   );
endinterface

// File: rtl/mm_idx_counter.sv
// Wrapping index counter with clear priority; wrap is a same-cycle carry for chaining.
module mm_idx_counter #(
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [IDX_W-1:0] cnt,
   output logic             wrap
);
   assign wrap = en & (cnt == {IDX_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + IDX_W'(1);
      end
   end
endmodule

// File: rtl/mm_mac_sequencer.sv
// Matmul control FSM: per C element 1 clear, DIM MAC, 1 write cycle; done one cycle after the last write.
// Stall freezes state and counters and masks strobes; the masked strobe repeats once stall drops.
module mm_mac_sequencer
   import mm_pkg::*;
#(
   parameter int DIM   = mm_pkg::DIM,
   parameter int IDX_W = mm_pkg::IDX_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mm_mac_sequencer_if.master   bus
);
   mm_seq_state_t      state;
   logic [IDX_W-1:0]   i, j, k;
   logic               k_wrap, j_wrap, i_wrap;
   logic               run_clr, k_en, j_en;
   logic               busy_q, done_q, clr_q, en_q, wr_q;
   logic [2*IDX_W-1:0] sel_a_q, sel_b_q, wr_addr_q;

   assign run_clr = (state == S_IDLE) & bus.start;
   assign k_en    = (state == S_MAC) & ~bus.stall;
   assign j_en    = (state == S_WB) & ~bus.stall;

   // j steps on every write-back and carries into i; i carrying out marks the final element.
   mm_idx_counter #(.IDX_W(IDX_W)) u_k (
      .clk(clk), .rst_n(rst_n), .en(k_en), .clr(run_clr), .cnt(k), .wrap(k_wrap)
   );
   mm_idx_counter #(.IDX_W(IDX_W)) u_j (
      .clk(clk), .rst_n(rst_n), .en(j_en), .clr(run_clr), .cnt(j), .wrap(j_wrap)
   );
   mm_idx_counter #(.IDX_W(IDX_W)) u_i (
      .clk(clk), .rst_n(rst_n), .en(j_wrap), .clr(run_clr), .cnt(i), .wrap(i_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         clr_q     <= 1'b0;
         en_q      <= 1'b0;
         wr_q      <= 1'b0;
         sel_a_q   <= '0;
         sel_b_q   <= '0;
         wr_addr_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state  <= S_CLR;
                  busy_q <= 1'b1;
                  clr_q  <= 1'b1;
               end
            end
            S_CLR: begin
               if (!bus.stall) begin
                  state   <= S_MAC;
                  clr_q   <= 1'b0;
                  en_q    <= 1'b1;
                  sel_a_q <= elem_idx(i, k);
                  sel_b_q <= elem_idx(k, j);
               end
            end
            S_MAC: begin
               if (!bus.stall) begin
                  if (k_wrap) begin
                     state     <= S_WB;
                     en_q      <= 1'b0;
                     wr_q      <= 1'b1;
                     wr_addr_q <= elem_idx(i, j);
                  end else begin
                     // Selects are registered, so load the operands for the next k now.
                     sel_a_q <= elem_idx(i, k + IDX_W'(1));
                     sel_b_q <= elem_idx(k + IDX_W'(1), j);
                  end
               end
            end
            S_WB: begin
               if (!bus.stall) begin
                  wr_q <= 1'b0;
                  if (i_wrap) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= S_CLR;
                     clr_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (!bus.stall) begin
                  state  <= S_IDLE;
                  done_q <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q & ~bus.stall;
   assign bus.mac_clr = clr_q & ~bus.stall;
   assign bus.mac_en  = en_q & ~bus.stall;
   assign bus.wr_en   = wr_q & ~bus.stall;
   assign bus.sel_a   = sel_a_q;
   assign bus.sel_b   = sel_b_q;
   assign bus.wr_addr = wr_addr_q;
endmodule

// File: tb/tb_mm_mac_sequencer.sv
// Bench for mm_mac_sequencer: a per-run schedule model checked every cycle, plus directed and random runs.
module tb_mm_mac_sequencer;
   import mm_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   mm_mac_sequencer_if bus();

   mm_mac_sequencer #(.DIM(DIM), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One entry per unstalled busy cycle of a complete run.
   typedef struct {
      bit clr;
      bit en;
      bit wr;
      bit dn;
      int sa;
      int sb;
      int wa;
   } rec_t;

   rec_t sched[$];

   function automatic void build_sched();
      rec_t r;
      for (int e = 0; e < DIM * DIM; e++) begin
         r = '{default: 0};
         r.clr = 1'b1;
         sched.push_back(r);
         for (int kk = 0; kk < DIM; kk++) begin
            r = '{default: 0};
            r.en = 1'b1;
            r.sa = (e / DIM) * DIM + kk;
            r.sb = kk * DIM + (e % DIM);
            sched.push_back(r);
         end
         r = '{default: 0};
         r.wr = 1'b1;
         r.wa = e;
         sched.push_back(r);
      end
      r = '{default: 0};
      r.dn = 1'b1;
      sched.push_back(r);
   endfunction

   int   pos = -1;
   int   ls_a = 0, ls_b = 0, lw = 0;
   int   cyc = 0, start_cyc = 0, rel = 0;
   int   stall_cnt = 0, wr_cnt = 0, mac_cnt = 0, next_wa = 0;
   bit   order_ok = 1'b1;
   int   runs_done = 0;
   int   last_done_rel = 0, last_wr = 0, last_mac = 0, last_stalls = 0;
   bit   last_ok = 1'b0;
   rec_t r_cur;
   logic st;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pos  = -1;
         ls_a = 0;
         ls_b = 0;
         lw   = 0;
         chk("rst_busy", bus.busy, 0);
         chk("rst_done", bus.done, 0);
         chk("rst_mac_clr", bus.mac_clr, 0);
         chk("rst_mac_en", bus.mac_en, 0);
         chk("rst_wr_en", bus.wr_en, 0);
         chk("rst_sel_a", bus.sel_a, 0);
         chk("rst_sel_b", bus.sel_b, 0);
         chk("rst_wr_addr", bus.wr_addr, 0);
      end else begin
         st    = bus.stall;
         r_cur = '{default: 0};
         if (pos >= 0) r_cur = sched[pos];
         if (r_cur.en) begin
            ls_a = r_cur.sa;
            ls_b = r_cur.sb;
         end
         if (r_cur.wr) lw = r_cur.wa;
         chk("busy", bus.busy, pos >= 0);
         chk("mac_clr", bus.mac_clr, r_cur.clr & !st);
         chk("mac_en", bus.mac_en, r_cur.en & !st);
         chk("wr_en", bus.wr_en, r_cur.wr & !st);
         chk("done", bus.done, r_cur.dn & !st);
         chk("sel_a", bus.sel_a, ls_a);
         chk("sel_b", bus.sel_b, ls_b);
         chk("wr_addr", bus.wr_addr, lw);

         if (pos >= 0) begin
            rel = cyc - start_cyc;
            if (st) stall_cnt++;
            if (bus.wr_en === 1'b1) begin
               wr_cnt++;
               if (int'(bus.wr_addr) != next_wa) order_ok = 1'b0;
               next_wa++;
            end
            if (bus.mac_en === 1'b1) mac_cnt++;
            // Hand-derived timeline for an unstalled run.
            if (stall_cnt == 0 && !st) begin
               if (rel >= 2 && rel <= 5) begin
                  chk("c00_sel_a", bus.sel_a, rel - 2);
                  chk("c00_sel_b", bus.sel_b, (rel - 2) * 4);
               end
               if (rel == 6) begin
                  chk("c00_wr_en", bus.wr_en, 1);
                  chk("c00_wr_addr", bus.wr_addr, 0);
               end
               if (rel >= 68 && rel <= 71) begin
                  chk("c23_sel_a", bus.sel_a, 8 + rel - 68);
                  chk("c23_sel_b", bus.sel_b, 3 + 4 * (rel - 68));
               end
               if (rel == 72) begin
                  chk("c23_wr_en", bus.wr_en, 1);
                  chk("c23_wr_addr", bus.wr_addr, 11);
               end
            end
            if (bus.done === 1'b1) begin
               last_done_rel = rel;
               last_wr       = wr_cnt;
               last_mac      = mac_cnt;
               last_ok       = order_ok;
               last_stalls   = stall_cnt;
               runs_done++;
            end
         end

         if (pos < 0) begin
            if (bus.start === 1'b1) begin
               pos       = 0;
               start_cyc = cyc;
               stall_cnt = 0;
               wr_cnt    = 0;
               mac_cnt   = 0;
               next_wa   = 0;
               order_ok  = 1'b1;
            end
         end else if (!st) begin
            pos++;
            if (pos == sched.size()) pos = -1;
         end
      end
   end

   int nrun = 0;

   task automatic do_start();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int want);
      int t = 0;
      while (runs_done < want && t < 600) begin
         @(posedge clk);
         t++;
      end
      chk("run_completed", runs_done >= want, 1);
   endtask

   task automatic drain();
      int t = 0;
      while (pos >= 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("drain_idle", pos < 0, 1);
      #1;
   endtask

   task automatic check_run(input string tag, input int exp_done_rel);
      chk({tag, "_done_cycle"}, last_done_rel, exp_done_rel);
      chk({tag, "_wr_count"}, last_wr, 16);
      chk({tag, "_mac_count"}, last_mac, 64);
      chk({tag, "_wr_order"}, last_ok, 1);
   endtask

   initial begin
      build_sched();
      bus.start = 1'b0;
      bus.stall = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Plain run, with a start pulse during busy that must be ignored.
      do_start();
      repeat (20) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      nrun++;
      wait_done(nrun);
      check_run("plain", 97);
      drain();

      // Three stall cycles while k=2 of C[0][0].
      do_start();
      repeat (3) @(posedge clk);
      #1 bus.stall = 1'b1;
      @(negedge clk);
      chk("stall_mac_en_low", bus.mac_en, 0);
      chk("stall_sel_a_hold", bus.sel_a, 2);
      chk("stall_sel_b_hold", bus.sel_b, 8);
      repeat (3) @(posedge clk);
      #1 bus.stall = 1'b0;
      @(negedge clk);
      chk("resume_mac_en", bus.mac_en, 1);
      chk("resume_sel_a", bus.sel_a, 2);
      chk("resume_sel_b", bus.sel_b, 8);
      nrun++;
      wait_done(nrun);
      check_run("stall3", 100);
      drain();

      // Asynchronous reset in cycle 40, then a clean run.
      do_start();
      repeat (39) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", bus.busy, 0);
      chk("async_rst_mac_en", bus.mac_en, 0);
      chk("async_rst_sel_a", bus.sel_a, 0);
      chk("async_rst_sel_b", bus.sel_b, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort_no_done", runs_done, nrun);
      do_start();
      nrun++;
      wait_done(nrun);
      check_run("post_rst", 97);
      drain();

      // Random stall density and stray start pulses.
      for (int r = 0; r < 6; r++) begin
         int pct;
         int t;
         pct = 10 + r * 8;
         t   = 0;
         nrun++;
         @(posedge clk);
         #1 bus.start = 1'b1;
         bus.stall = ($urandom_range(0, 99) < 50);
         @(posedge clk);
         #1 bus.start = 1'b0;
         while (runs_done < nrun && t < 800) begin
            bus.stall = ($urandom_range(0, 99) < pct);
            bus.start = ($urandom_range(0, 99) < 5);
            @(posedge clk);
            #1;
            t++;
         end
         bus.start = 1'b0;
         bus.stall = 1'b0;
         chk("rand_run_completed", runs_done >= nrun, 1);
         check_run("rand", 97 + last_stalls);
         drain();
         nrun = runs_done;
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
